// File: rtl/serial_rom_pkg.sv
// serial_rom_pkg: shared state encoding, default widths and counter sizing for the serial ROM responder
package serial_rom_pkg;
    typedef enum logic [1:0] {IDLE, RX_ADDR, TX_DATA} state_t;
    localparam int INSTR_ADDR_WIDTH = 8;
    localparam int INSTR_DATA_WIDTH = 32;
    localparam int MICRO_ADDR_WIDTH = 9;
    localparam int MICRO_DATA_WIDTH = 44;
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/serial_rom_array.sv
// serial_rom_array: DEPTH x DATA_WIDTH storage, synchronous write, asynchronous range-checked read
module serial_rom_array
    import serial_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH,
    parameter int DATA_WIDTH = INSTR_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_valid
);
    localparam int WA = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    // contents are never reset so a chip reset keeps the loaded program
    always_ff @(posedge clock)
        if (wr_en && 32'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
    assign rd_valid = 32'(rd_addr) < DEPTH;
    assign rd_data  = rd_valid ? mem[WA'(rd_addr)] : '0;
endmodule

// File: rtl/serial_rom_responder.sv
// serial_rom_responder: bit-serial address in, stored word out MSB first; SERIAL_ROM_PARITY_EN appends an even-parity bit
module serial_rom_responder
    import serial_rom_pkg::*;
#(
    parameter int ADDR_WIDTH = INSTR_ADDR_WIDTH,
    parameter int DATA_WIDTH = INSTR_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_en,
    input  logic                     addr_bit,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     data_bit,
    output logic                     tx_active,
    output logic                     busy,
    output logic                     proto_err
);
`ifdef SERIAL_ROM_PARITY_EN
    localparam int TX_LEN = DATA_WIDTH + 1;
`else
    localparam int TX_LEN = DATA_WIDTH;
`endif
    localparam int CW = cnt_width(ADDR_WIDTH > TX_LEN ? ADDR_WIDTH : TX_LEN);
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] ash;
    logic [TX_LEN-1:0]     txsh;
    logic [ADDR_WIDTH-1:0] full_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [TX_LEN-1:0]     load_word;
    // the incoming bit completes the address on the final-bit edge, so the array sees it combinationally
    assign full_addr = ADDR_WIDTH'({ash, addr_bit});
`ifdef SERIAL_ROM_PARITY_EN
    assign load_word = {rd_data, ^rd_data};
`else
    assign load_word = rd_data;
`endif
    serial_rom_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH)
    ) u_array (
        .clock(clock),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(full_addr),
        .rd_data(rd_data),
        .rd_valid(rd_valid)
    );
    // zeros shift in behind the word, so data_bit falls to 0 on its own once the word is out
    assign data_bit  = txsh[TX_LEN-1];
    assign tx_active = state == TX_DATA;
    assign busy      = state != IDLE;
    // address capture, zero-bubble turnaround into transmit, and sticky protocol error
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ash       <= '0;
            txsh      <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                IDLE, RX_ADDR: begin
                    if (rx_en) begin
                        ash <= full_addr;
                        if (cnt == CW'(ADDR_WIDTH - 1)) begin
                            state <= TX_DATA;
                            cnt   <= '0;
                            txsh  <= load_word;
                            if (!rd_valid) proto_err <= 1'b1;
                        end else begin
                            state <= RX_ADDR;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    txsh <= txsh << 1;
                    if (rx_en) proto_err <= 1'b1;
                    if (cnt == CW'(TX_LEN - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_serial_rom_responder.sv
// tb_serial_rom_responder: random and directed transactions on instruction (8/32) and micro (9/44) instances against a word-level model
module tb_serial_rom_responder;
`ifdef SERIAL_ROM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic clock = 0;
    logic reset = 0;
    logic rx_en = 0, addr_bit = 0, wr_en = 0, sel = 0;
    logic [4:0] wr_addr = '0;
    logic [43:0] wr_data = '0;
    logic d_bit, d_act, d_busy, d_err, m_bit, m_act, m_busy, m_err;
    logic bit_o, act_o, busy_o, err_o;
    int errors = 0, checks = 0;
    int aw = 8, dw = 32, dep = 16;
    logic [43:0] mem [2][32];
    bit err_m [2];

    always #5 clock = ~clock;

    serial_rom_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16)) u_dut (
        .clock(clock), .reset(reset), .rx_en(rx_en & ~sel), .addr_bit(addr_bit),
        .wr_en(wr_en & ~sel), .wr_addr(wr_addr[3:0]), .wr_data(wr_data[31:0]),
        .data_bit(d_bit), .tx_active(d_act), .busy(d_busy), .proto_err(d_err));

    serial_rom_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(44), .DEPTH(20)) u_micro (
        .clock(clock), .reset(reset), .rx_en(rx_en & sel), .addr_bit(addr_bit),
        .wr_en(wr_en & sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .data_bit(m_bit), .tx_active(m_act), .busy(m_busy), .proto_err(m_err));

    assign bit_o  = sel ? m_bit : d_bit;
    assign act_o  = sel ? m_act : d_act;
    assign busy_o = sel ? m_busy : d_busy;
    assign err_o  = sel ? m_err : d_err;

    function automatic logic [43:0] mask(input logic [43:0] d);
        return d & ((44'h1 << dw) - 44'h1);
    endfunction

    function automatic logic [43:0] expect_word(input int a);
        return (a < dep) ? mem[sel][a] : 44'h0;
    endfunction

    task automatic pick(input bit s);
        sel = s;
        aw  = s ? 9 : 8;
        dw  = s ? 44 : 32;
        dep = s ? 20 : 16;
    endtask

    task automatic load(input int a, input logic [43:0] d);
        @(negedge clock);
        wr_en = 1; wr_addr = a[4:0]; wr_data = d;
        @(posedge clock);
        #1 wr_en = 0;
        mem[sel][a] = mask(d);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        reset = 1;
        err_m[0] = 0; err_m[1] = 0;
    endtask

    task automatic send_addr(input int a, input int gap_at, input int gap_len, input bit wr_final, input logic [43:0] wd);
        logic [8:0] av;
        av = a[8:0];
        for (int i = 0; i < aw; i++) begin
            @(negedge clock);
            if (i == 0) begin
                checks++;
                if (busy_o !== 1'b0 || act_o !== 1'b0 || bit_o !== 1'b0 || err_o !== err_m[sel]) begin
                    errors++;
                    $display("FAIL idle_before_req: busy=%b act=%b bit=%b err=%b, want 0 0 0 %b", busy_o, act_o, bit_o, err_o, err_m[sel]);
                end
            end
            if (i == gap_at) repeat (gap_len) begin
                rx_en = 0; wr_en = 0;
                checks++;
                if (busy_o !== 1'b1 || act_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_gap: busy=%b act=%b, want 1 0", busy_o, act_o);
                end
                @(negedge clock);
            end
            rx_en = 1; addr_bit = av[aw-1-i]; wr_en = 0;
            if (i == aw - 1 && wr_final) begin
                wr_en = 1; wr_addr = a[4:0]; wr_data = wd;
            end
        end
    endtask

    task automatic recv(input logic [43:0] w, input string name, input int rx_at, input int wr_at, input int wa, input logic [43:0] wd, input int stop_at);
        logic e;
        for (int i = 0; i < dw + PAR && i < stop_at; i++) begin
            @(negedge clock);
            rx_en = (i == rx_at); wr_en = (i == wr_at);
            if (i == wr_at) begin wr_addr = wa[4:0]; wr_data = wd; end
            e = (i < dw) ? w[dw-1-i] : ^w;
            checks++;
            if (act_o !== 1'b1 || busy_o !== 1'b1 || bit_o !== e) begin
                errors++;
                $display("FAIL %s bit %0d: act=%b busy=%b data_bit=%b, want 1 1 %b", name, i, act_o, busy_o, bit_o, e);
            end
        end
    endtask

    task automatic txn(input int a, input int gap_at, input int gap_len, input int rx_at, input bit wr_final,
                       input logic [43:0] wd, input int wr_at, input logic [43:0] wd2, input string name);
        logic [43:0] w;
        w = expect_word(a);
        send_addr(a, gap_at, gap_len, wr_final, wd);
        if (a >= dep) err_m[sel] = 1;
        if (wr_final) mem[sel][a] = mask(wd);
        recv(w, name, rx_at, wr_at, a, wd2, 1000);
        if (wr_at >= 0) mem[sel][a] = mask(wd2);
        if (rx_at >= 0) err_m[sel] = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(negedge clock);
        checks++;
        if ({d_bit, d_act, d_busy, d_err, m_bit, m_act, m_busy, m_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 00000000", {d_bit, d_act, d_busy, d_err, m_bit, m_act, m_busy, m_err});
        end
        reset = 1;
    endtask

    task automatic test_basic();
        pick(0);
        load(3, 44'hDEADBEEF);
        txn(3, -1, 0, -1, 0, 0, -1, 0, "basic_deadbeef");
        load(1, 44'h7);
        txn(1, -1, 0, -1, 0, 0, -1, 0, "word_7");
    endtask

    task automatic test_gap();
        txn(3, 4, 2, -1, 0, 0, -1, 0, "gap_deadbeef");
        txn(15, 1, 3, -1, 0, 0, -1, 0, "gap_last_addr");
    endtask

    task automatic test_out_of_range();
        txn(32'h20, -1, 0, -1, 0, 0, -1, 0, "oor_0x20");
        txn(16, -1, 0, -1, 0, 0, -1, 0, "oor_16");
        @(negedge clock);
        checks++;
        if (d_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_proto_err: got %b, want 1", d_err);
        end
        pulse_reset();
    endtask

    task automatic test_write_final();
        load(5, 44'hAAAAAAAA);
        txn(5, -1, 0, -1, 1, 44'h12345678, -1, 0, "write_final_old");
        txn(5, -1, 0, -1, 0, 0, -1, 0, "back_to_back_new");
    endtask

    task automatic test_write_in_tx();
        txn(3, -1, 0, -1, 0, 0, 5, 44'hCAFEF00D, "write_in_tx_old");
        txn(3, -1, 0, -1, 0, 0, -1, 0, "write_in_tx_new");
        load(3, 44'hDEADBEEF);
    endtask

    task automatic test_rx_in_tx();
        txn(3, -1, 0, 7, 0, 0, -1, 0, "rx_in_tx");
        @(negedge clock);
        checks++;
        if (d_err !== 1'b1 || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_in_tx_err: err=%b busy=%b, want 1 0", d_err, d_busy);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid();
        send_addr(3, -1, 0, 0, 0);
        recv(mem[0][3], "pre_reset", -1, -1, 0, 0, 10);
        #2 reset = 0;
        #1;
        checks++;
        if ({d_bit, d_act, d_busy, d_err} !== 4'h0) begin
            errors++;
            $display("FAIL async_reset_mid_tx: got %b, want 0000", {d_bit, d_act, d_busy, d_err});
        end
        @(negedge clock);
        reset = 1;
        err_m[0] = 0; err_m[1] = 0;
        txn(3, -1, 0, -1, 0, 0, -1, 0, "after_reset");
    endtask

    task automatic test_micro();
        pick(1);
        load(0, 44'hF0F_1234_5678);
        load(19, 44'hABC_DEF0_1357);
        load(7, {$urandom, $urandom});
        txn(0, -1, 0, -1, 0, 0, -1, 0, "micro_0");
        txn(19, 3, 1, -1, 0, 0, -1, 0, "micro_19");
        txn(7, -1, 0, -1, 0, 0, -1, 0, "micro_7");
        txn(300, -1, 0, -1, 0, 0, -1, 0, "micro_oor");
        pulse_reset();
    endtask

    task automatic test_random();
        int a, g, gl;
        for (int k = 0; k < 16; k++) begin
            pick(1'($urandom_range(0, 1)));
            a = $urandom_range(0, dep + 3);
            if ($urandom_range(0, 1) == 1) load(a % dep, {$urandom, $urandom});
            g = $urandom_range(1, aw - 1);
            gl = $urandom_range(0, 3);
            txn(a, g, gl, -1, 0, 0, -1, 0, "random");
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) mem[s][i] = '0;
        test_reset();
        pick(0);
        for (int i = 0; i < 16; i++) load(i, 44'h0);
        pick(1);
        for (int i = 0; i < 20; i++) load(i, 44'h0);
        test_basic();
        test_gap();
        test_out_of_range();
        test_write_final();
        test_write_in_tx();
        test_rx_in_tx();
        test_reset_mid();
        test_micro();
        test_random();
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
